// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer: frames enter in natural order and leave bit-reversed.
// Optional macro FFT_BITREV_PRESCALE_EN stores each component arithmetically halved.
module fft_bitrev_buf #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = '1;
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);

    logic [2*WIDTH-1:0] mem [2*N];
    logic [LOG2N-1:0]   wcnt;
    logic [LOG2N-1:0]   rcnt;
    logic [LOG2N-1:0]   raddr;
    logic               wbank;
    logic               rbank;
    logic [1:0]         full;
    logic [WIDTH-1:0]   st_re;
    logic [WIDTH-1:0]   st_im;
    logic               accept;
    logic               xfer;

`ifdef FFT_BITREV_PRESCALE_EN
    // One bit of headroom for the butterfly growth that follows.
    assign st_re = $signed(in_re) >>> 1;
    assign st_im = $signed(in_im) >>> 1;
`else
    assign st_re = in_re;
    assign st_im = in_im;
`endif

    assign in_ready  = !full[wbank];
    assign out_valid = full[rbank];
    assign out_last  = out_valid && (rcnt == LAST_IDX);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        raddr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            raddr[LOG2N-1-i] = rcnt[i];
        end
    end

    assign {out_re, out_im} = mem[{rbank, raddr}];

    // Sample storage is never cleared; out_valid masks whatever it holds.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[{wbank, wcnt}] <= {st_re, st_im};
        end
    end

    // Fill and drain always target different banks, so both may complete together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt  <= '0;
            rcnt  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
        end else begin
            if (accept) begin
                wcnt <= wcnt + ONE;
                if (wcnt == LAST_IDX) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                end
            end
            if (xfer) begin
                rcnt <= rcnt + ONE;
                if (rcnt == LAST_IDX) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                end
            end
        end
    end

endmodule
